// File: rtl/sourceout_ctrl_gen.sv
// Stroke-gating read controller for the post-processing FIFO: waits for fill, then alternates
// scaled positive (FIFO read) and negative (zero-fill) strokes, pausing on underrun.
module sourceout_ctrl_gen #(
  parameter int LEN_W     = 32,
  parameter int CNT_W     = 48,
  parameter int USEDW_W   = 13,
  parameter int START_LVL = 2000,
  parameter int STAT_W    = 16
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               run,
  input  logic [LEN_W-1:0]   pos_length,
  input  logic [LEN_W-1:0]   neg_length,
  input  logic [3:0]         data_form,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               data_en,
  output logic [1:0]         phase,
  output logic               underrun,
  output logic               cfg_err,
  output logic [STAT_W-1:0]  stroke_cnt,
  output logic [STAT_W-1:0]  underrun_cnt
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_FILL = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_SEND_POS  = 3'd3;
  localparam logic [2:0] S_SEND_NEG  = 3'd4;
  localparam logic [2:0] S_PAUSE     = 3'd5;

  localparam logic [USEDW_W-1:0] START_THR = USEDW_W'(START_LVL);
  localparam logic [STAT_W-1:0]  STAT_MAX  = '1;

  function automatic logic [CNT_W-1:0] scale_len(input logic [LEN_W-1:0] len,
                                                 input logic [3:0]       form);
    logic [CNT_W-1:0] ext;
    ext = CNT_W'(len);
    case (form)
      4'd1:    scale_len = ext << 3;
      4'd2:    scale_len = ext << 2;
      4'd3:    scale_len = ext << 1;
      4'd5:    scale_len = ext >> 1;
      4'd6:    scale_len = ext >> 2;
      default: scale_len = ext;
    endcase
  endfunction

  logic [2:0]         state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [CNT_W-1:0]   pos_num, pos_num_nxt;
  logic [CNT_W-1:0]   neg_num, neg_num_nxt;
  logic [CNT_W-1:0]   scaled_pos, scaled_neg;
  logic [USEDW_W-1:0] usedw_r;
  logic [1:0]         phase_nxt;
  logic               fill_ok, err_set, stroke_done, pause_hit, relatch;

  assign scaled_pos = scale_len(pos_length, data_form);
  assign scaled_neg = scale_len(neg_length, data_form);
  assign fill_ok    = (usedw_r > START_THR);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_nxt   = state;
    count_nxt   = count;
    pos_num_nxt = pos_num;
    neg_num_nxt = neg_num;
    err_set     = 1'b0;
    stroke_done = 1'b0;
    pause_hit   = 1'b0;
    relatch     = 1'b0;
    case (state)
      S_IDLE: if (run) state_nxt = S_WAIT_FILL;
      S_WAIT_FILL: begin
        if (!run)         state_nxt = S_IDLE;
        else if (fill_ok) state_nxt = S_START;
      end
      S_START: begin
        pos_num_nxt = scaled_pos;
        neg_num_nxt = scaled_neg;
        if (!run)                  state_nxt = S_IDLE;
        else if (scaled_pos == '0) err_set   = 1'b1;
        else begin
          count_nxt = '0;
          state_nxt = S_SEND_POS;
        end
      end
      S_SEND_POS: begin
        // The read in the final cycle always completes the stroke, even if the FIFO ran dry.
        if (count == pos_num - CNT_W'(1)) begin
          stroke_done = 1'b1;
          count_nxt   = '0;
          if (!run)                state_nxt = S_IDLE;
          else if (neg_num == '0)  relatch   = 1'b1;
          else                     state_nxt = S_SEND_NEG;
        end else begin
          count_nxt = count + CNT_W'(1);
          if (usedw_r == '0) begin
            pause_hit = 1'b1;
            state_nxt = S_PAUSE;
          end
        end
      end
      S_SEND_NEG: begin
        if (!run)                              state_nxt = S_IDLE;
        else if (count == neg_num - CNT_W'(1)) relatch   = 1'b1;
        else                                   count_nxt = count + CNT_W'(1);
      end
      S_PAUSE: begin
        if (!run)         state_nxt = S_IDLE;
        else if (fill_ok) state_nxt = S_SEND_POS;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A zero-length positive stroke after re-latching falls back to START to flag cfg_err.
    if (relatch) begin
      pos_num_nxt = scaled_pos;
      neg_num_nxt = scaled_neg;
      count_nxt   = '0;
      state_nxt   = (scaled_pos == '0) ? S_START : S_SEND_POS;
    end
  end

  always_comb begin
    phase_nxt = 2'd0;
    case (state_nxt)
      S_SEND_POS: phase_nxt = 2'd1;
      S_SEND_NEG: phase_nxt = 2'd2;
      S_PAUSE:    phase_nxt = 2'd3;
      default:    phase_nxt = 2'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (RST) begin
      state        <= S_IDLE;
      count        <= '0;
      pos_num      <= '0;
      neg_num      <= '0;
      usedw_r      <= '0;
      data_en      <= 1'b0;
      phase        <= 2'd0;
      underrun     <= 1'b0;
      cfg_err      <= 1'b0;
      stroke_cnt   <= '0;
      underrun_cnt <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      pos_num  <= pos_num_nxt;
      neg_num  <= neg_num_nxt;
      usedw_r  <= fifo_usedw;
      data_en  <= (state_nxt == S_SEND_POS);
      phase    <= phase_nxt;
      underrun <= pause_hit;
      if (!run)         cfg_err <= 1'b0;
      else if (err_set) cfg_err <= 1'b1;
      if (stroke_done && stroke_cnt != STAT_MAX)
        stroke_cnt <= stroke_cnt + STAT_W'(1);
      if (pause_hit && underrun_cnt != STAT_MAX)
        underrun_cnt <= underrun_cnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_sourceout_ctrl_gen.sv
// Bench for sourceout_ctrl_gen: stroke-shape table, hand-built corner sequences and random
// stimulus, all watched cycle by cycle by a stroke-level reference model.
module tb_sourceout_ctrl_gen;

  localparam int LEN_W   = 32;
  localparam int CNT_W   = 48;
  localparam int USEDW_W = 13;
  localparam int LVL     = 2000;
  localparam int STAT_W  = 6;
  localparam int SAT     = (1 << STAT_W) - 1;

  logic               clk = 1'b0;
  logic               RST = 1'b1;
  logic               run = 1'b0;
  logic [LEN_W-1:0]   pos_length = '0;
  logic [LEN_W-1:0]   neg_length = '0;
  logic [3:0]         data_form = 4'd4;
  logic [USEDW_W-1:0] fifo_usedw = '0;
  logic               data_en;
  logic [1:0]         phase;
  logic               underrun;
  logic               cfg_err;
  logic [STAT_W-1:0]  stroke_cnt;
  logic [STAT_W-1:0]  underrun_cnt;

  sourceout_ctrl_gen #(
    .LEN_W(LEN_W), .CNT_W(CNT_W), .USEDW_W(USEDW_W), .START_LVL(LVL), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .RST(RST), .run(run), .pos_length(pos_length), .neg_length(neg_length),
    .data_form(data_form), .fifo_usedw(fifo_usedw), .data_en(data_en), .phase(phase),
    .underrun(underrun), .cfg_err(cfg_err), .stroke_cnt(stroke_cnt), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: stroke bookkeeping with remaining-cycle counters
  typedef enum {M_OFF, M_ARM, M_LOAD, M_HI, M_LO, M_HOLD} mmode_t;
  mmode_t m_mode;
  longint m_left, m_pos, m_neg;
  int     m_lvl, m_strk, m_undr, e_phase;
  bit     m_err, e_en, e_ur, m_valid = 0, m_fill, m_ur;

  function automatic longint scaled(input longint l, input int f);
    case (f)
      1: return l * 8;
      2: return l * 4;
      3: return l * 2;
      5: return l / 2;
      6: return l / 4;
      default: return l;
    endcase
  endfunction

  task automatic m_reload();
    m_pos = scaled(longint'(pos_length), int'(data_form));
    m_neg = scaled(longint'(neg_length), int'(data_form));
    if (m_pos == 0) m_mode = M_LOAD;
    else begin m_mode = M_HI; m_left = m_pos; end
  endtask

  always @(posedge clk) begin
    if (RST) begin
      m_mode = M_OFF; m_left = 0; m_pos = 0; m_neg = 0; m_lvl = 0;
      m_strk = 0; m_undr = 0; m_err = 0; m_valid = 1;
      e_en = 0; e_phase = 0; e_ur = 0;
    end else if (m_valid) begin
      m_fill = (m_lvl > LVL);
      m_ur   = 0;
      case (m_mode)
        M_OFF:  if (run) m_mode = M_ARM;
        M_ARM:  if (!run) m_mode = M_OFF; else if (m_fill) m_mode = M_LOAD;
        M_LOAD: begin
          m_pos = scaled(longint'(pos_length), int'(data_form));
          m_neg = scaled(longint'(neg_length), int'(data_form));
          if (!run) m_mode = M_OFF;
          else if (m_pos == 0) m_err = 1;
          else begin m_mode = M_HI; m_left = m_pos; end
        end
        M_HI: begin
          m_left--;
          if (m_left == 0) begin
            if (m_strk < SAT) m_strk++;
            if (!run) m_mode = M_OFF;
            else if (m_neg == 0) m_reload();
            else begin m_mode = M_LO; m_left = m_neg; end
          end else if (m_lvl == 0) begin
            m_mode = M_HOLD; m_ur = 1;
            if (m_undr < SAT) m_undr++;
          end
        end
        M_LO: begin
          if (!run) m_mode = M_OFF;
          else begin
            m_left--;
            if (m_left == 0) m_reload();
          end
        end
        M_HOLD: if (!run) m_mode = M_OFF; else if (m_fill) m_mode = M_HI;
        default: m_mode = M_OFF;
      endcase
      if (!run) m_err = 0;
      m_lvl   = int'(fifo_usedw);
      e_en    = (m_mode == M_HI);
      e_phase = (m_mode == M_HI) ? 1 : (m_mode == M_LO) ? 2 : (m_mode == M_HOLD) ? 3 : 0;
      e_ur    = m_ur;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [16:0] act, exp;
      act = {data_en, phase, underrun, cfg_err, stroke_cnt, underrun_cnt};
      exp = {e_en, 2'(e_phase), e_ur, m_err, STAT_W'(m_strk), STAT_W'(m_undr)};
      check("model", longint'(act), longint'(exp));
    end
  end

  // ---------------- helpers (all stimulus changes happen on the falling edge)
  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1; run = 1'b0; fifo_usedw = '0;
    @(negedge clk);
    @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic wait_en(input string name, input int budget);
    int c = 0;
    while (!data_en && c < budget) begin @(negedge clk); c++; end
    check(name, longint'(data_en), 1);
  endtask

  task automatic wait_strokes(input string name, input int target, input int budget);
    int c = 0;
    while (int'(stroke_cnt) != target && c < budget) begin @(negedge clk); c++; end
    check(name, longint'(stroke_cnt), longint'(target));
  endtask

  typedef struct {
    logic [3:0] form;
    int         pos;
    int         neg;
    int         exp_hi;
    int         exp_lo;
    bit         exp_err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat, seen, reads, pulses, drop_at, cyc, ones;
    bit paused;
    logic [15:0] pat;

    vecs[0]  = '{4'd4,  5, 3,  5, 3, 1'b0};
    vecs[1]  = '{4'd1,  2, 0, 16, 0, 1'b0};
    vecs[2]  = '{4'd2,  1, 1,  4, 4, 1'b0};
    vecs[3]  = '{4'd3,  3, 2,  6, 4, 1'b0};
    vecs[4]  = '{4'd5,  7, 4,  3, 2, 1'b0};
    vecs[5]  = '{4'd6,  9, 8,  2, 2, 1'b0};
    vecs[6]  = '{4'd0,  3, 1,  3, 1, 1'b0};
    vecs[7]  = '{4'd15, 2, 5,  2, 5, 1'b0};
    vecs[8]  = '{4'd6,  4, 1,  1, 0, 1'b0};
    vecs[9]  = '{4'd5,  1, 3,  0, 0, 1'b1};
    vecs[10] = '{4'd6,  3, 0,  0, 0, 1'b1};

    do_reset();
    check("reset_state", longint'({data_en, phase, underrun, cfg_err, stroke_cnt, underrun_cnt}), 0);

    // Stroke shapes: one full period between the first and second completed strokes.
    foreach (vecs[i]) begin
      do_reset();
      data_form = vecs[i].form; pos_length = vecs[i].pos; neg_length = vecs[i].neg;
      fifo_usedw = 13'd2001; run = 1'b1;
      if (vecs[i].exp_err) begin
        seen = 0;
        repeat (12) begin @(negedge clk); if (data_en) seen++; end
        check($sformatf("tbl%0d_err", i), longint'(cfg_err), 1);
        check($sformatf("tbl%0d_no_en", i), seen, 0);
      end else begin
        wait_strokes($sformatf("tbl%0d_first", i), 1, 200);
        cyc = 0; ones = 0;
        while (stroke_cnt == 1 && cyc < 200) begin
          if (data_en) ones++;
          cyc++;
          @(negedge clk);
        end
        check($sformatf("tbl%0d_period", i), cyc, vecs[i].exp_hi + vecs[i].exp_lo);
        check($sformatf("tbl%0d_ones", i), ones, vecs[i].exp_hi);
      end
    end

    // Threshold is strictly greater-than, then start latency and the 11111000 pattern.
    do_reset();
    data_form = 4'd4; pos_length = 5; neg_length = 3; fifo_usedw = 13'd2000; run = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (data_en) seen++; end
    check("thresh_equal_no_start", seen, 0);
    fifo_usedw = 13'd2001;
    lat = 0;
    while (!data_en && lat < 10) begin @(negedge clk); lat++; end
    check("start_latency_le3", longint'(lat <= 3 && data_en), 1);
    for (int k = 15; k >= 0; k--) begin
      pat[k] = data_en;
      @(negedge clk);
    end
    check("t1_pattern", longint'(pat), longint'(16'b1111100011111000));

    // Underrun mid-stroke: pause, resume at the held count, stroke total stays 10.
    do_reset();
    data_form = 4'd4; pos_length = 10; neg_length = 2; fifo_usedw = 13'd2500; run = 1'b1;
    wait_en("t4_start", 20);
    reads = 0; pulses = 0; drop_at = -1; paused = 0;
    for (int c = 0; c < 100 && stroke_cnt == 0; c++) begin
      if (data_en) reads++;
      if (underrun) pulses++;
      if (phase == 2'd3) paused = 1;
      if (reads == 4 && drop_at < 0) begin fifo_usedw = '0; drop_at = c; end
      if (drop_at >= 0 && c == drop_at + 6) fifo_usedw = 13'd2500;
      @(negedge clk);
    end
    check("t4_reads", reads, 10);
    check("t4_pulses", pulses, 1);
    check("t4_paused", longint'(paused), 1);
    check("t4_underrun_cnt", longint'(underrun_cnt), 1);

    // run=0 mid positive stroke completes it; run=0 in a negative stroke abandons it.
    do_reset();
    data_form = 4'd4; pos_length = 8; neg_length = 3; fifo_usedw = 13'd2500; run = 1'b1;
    wait_en("t5_start", 20);
    reads = 0;
    for (int c = 0; c < 50 && stroke_cnt == 0; c++) begin
      if (data_en) reads++;
      if (reads == 3) run = 1'b0;
      @(negedge clk);
    end
    check("t5_reads", reads, 8);
    check("t5_idle_en", longint'(data_en), 0);
    repeat (3) @(negedge clk);
    check("t5_idle_phase", longint'(phase), 0);
    run = 1'b1;
    wait_strokes("t5_second", 2, 40);
    check("t5_neg_phase", longint'(phase), 2);
    run = 1'b0;
    @(negedge clk);
    check("t5_neg_abandon", longint'({data_en, phase}), 0);
    run = 1'b1;
    wait_en("t5_restart", 20);
    RST = 1'b1;
    @(negedge clk);
    check("t5_rst_mid", longint'({data_en, phase, underrun, cfg_err, stroke_cnt, underrun_cnt}), 0);
    RST = 1'b0;

    // cfg_err: sticky while running, cleared by run=0.
    do_reset();
    data_form = 4'd5; pos_length = 1; neg_length = 2; fifo_usedw = 13'd2500; run = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (data_en) seen++; end
    check("t3_err", longint'(cfg_err), 1);
    check("t3_no_en", seen, 0);
    pos_length = 4;
    wait_en("t3_recover", 10);
    reads = 0;
    for (int c = 0; c < 20 && stroke_cnt == 0; c++) begin
      if (data_en) reads++;
      @(negedge clk);
    end
    check("t3_stroke_len", reads, 2);
    check("t3_err_sticky", longint'(cfg_err), 1);
    run = 1'b0;
    @(negedge clk);
    check("t3_err_clear", longint'(cfg_err), 0);

    // Saturation with back-to-back 1-cycle strokes.
    do_reset();
    data_form = 4'd6; pos_length = 4; neg_length = 1; fifo_usedw = 13'd2500; run = 1'b1;
    repeat (80) @(negedge clk);
    check("sat_stroke_cnt", longint'(stroke_cnt), SAT);
    check("sat_en_high", longint'(data_en), 1);

    // Random traffic, checked by the model every cycle.
    do_reset();
    run = 1'b1; data_form = 4'd4; pos_length = 3; neg_length = 2; fifo_usedw = 13'd2500;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 5))
          0:       fifo_usedw = '0;
          1:       fifo_usedw = 13'd2000;
          2:       fifo_usedw = 13'd2001;
          3:       fifo_usedw = 13'd2500;
          4:       fifo_usedw = 13'd100;
          default: fifo_usedw = 13'd3000;
        endcase
      end
      if ($urandom_range(0, 29) == 0) begin
        pos_length = $urandom_range(0, 6);
        neg_length = $urandom_range(0, 5);
        data_form  = 4'($urandom_range(0, 15));
      end
      RST = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
